mc14500_seq: RTL and testbench
==============================

MC14500_SEQ -- requirements
Module: mc14500_seq

Interface
REQ-001 Parameter AW, default 8: program-counter width and operand-field width.
REQ-002 Parameter DEPTH, default 4: return-stack depth in entries, range 1..16.
REQ-003 X2  in  1  clock; all state updates on posedge X2, shared with the ICU.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 ROM_ADDR  out  AW  program memory address, equal to PC.
REQ-006 ROM_DATA  in  4+AW  program word, asynchronous read: [AW+3:AW] opcode, [AW-1:0] operand.
REQ-007 I  out  4  opcode to the ICU, equal to IR.
REQ-008 IO_ADDR  out  AW  operand of the current instruction, equal to OPR (I/O select or jump target).
REQ-009 JMP, RTN, FLAG_F  in  1 each  decoded strobes from the ICU for the current instruction.
REQ-010 RUN  in  1  resume request while halted.
REQ-011 HALTED  out  1  sequencer halted.
REQ-012 STK_OVF, STK_UNF  out  1 each  sticky stack-overflow and stack-underflow flags.
REQ-013 SP  out  clog2(DEPTH+1)  number of valid stack entries.

Function
REQ-014 Registers: PC (AW), IR (4), OPR (AW), stack DEPTH x AW, SP, HALTED, STK_OVF, STK_UNF.
REQ-015 Normal fetch, when HALTED=0 and JMP, RTN and FLAG_F are all 0: IR<=ROM_DATA opcode, OPR<=ROM_DATA operand, PC<=PC+1 mod 2^AW.
REQ-016 The ICU latches I on negedge X2, so an instruction fetched at posedge k drives JMP/RTN/FLAG_F, which the sequencer samples at posedge k+1.
REQ-017 Bubble = IR<=4'h0 (NOPO), OPR<=0; every redirect inserts exactly one bubble.
REQ-018 JMP=1 at posedge: if SP<DEPTH, push PC and SP<=SP+1; PC<=OPR; bubble.
REQ-019 JMP=1 with SP=DEPTH: no push, STK_OVF<=1, PC<=OPR, bubble.
REQ-020 The pushed PC is the address after the JMP word (the fetch address in that cycle).
REQ-021 RTN=1 with SP>0: PC<=stack[SP-1], SP<=SP-1, bubble.
REQ-022 RTN=1 with SP=0: PC<=0, STK_UNF<=1, SP stays 0, bubble.
REQ-023 FLAG_F=1 with HALTED=0: HALTED<=1, PC holds, bubble; RUN in the same cycle is ignored.
REQ-024 While HALTED=1: PC, SP and the stack hold; IR=0 and OPR=0; JMP, RTN and FLAG_F are ignored.
REQ-025 RUN=1 while HALTED=1: HALTED<=0 with no fetch on that edge; fetch resumes at PC on the next edge.
REQ-026 Priority when strobes are simultaneous: JMP > RTN > FLAG_F.
REQ-027 STK_OVF and STK_UNF clear only on reset.
REQ-028 The ICU's SKZ skip needs no sequencer action; the fetch stream continues.

Reset
REQ-029 RST_N=0 asynchronously forces PC=0, IR=0, OPR=0, SP=0, HALTED=0, STK_OVF=0, STK_UNF=0; stack contents are don't-care.
REQ-030 After RST_N rises, the first posedge fetches ROM[0].
REQ-031 Reset asserted mid-redirect or mid-halt aborts the operation completely, leaving no pending push, pop or halt.

Verification
REQ-032 Linear run: ROM 0..3 = LD/STO/OR/STO with operands 5,6,7,8 -> ROM_ADDR 0,1,2,3 on successive edges; IO_ADDR follows 5,6,7,8 one cycle later.
REQ-033 Call/return: ROM[2]=JMP 0x40, ROM[0x40]=RTN -> PC=0x40, SP=1, stack[0]=3; then PC=3, SP=0; exactly one bubble after each redirect.
REQ-034 Overflow: DEPTH=4, five nested JMPs -> SP=4, STK_OVF=1 after the fifth; the fifth target is still fetched.
REQ-035 Underflow plus halt: RTN with SP=0 -> PC=0, STK_UNF=1; NOPF at address 9 -> HALTED=1, PC=0x0A held; RUN pulse -> ROM[0x0A] fetched on the following edge.
REQ-036 Wrap and reset: AW=8, PC=0xFF -> next PC=0x00; RST_N low mid-JMP -> all registers zero and no push recorded.

Source files
------------

// File: rtl/mc14500_seq.sv
`default_nettype none
// ============================================================================
// Module   : mc14500_seq
// Purpose  : Program sequencer for an MC14500 ICU. It fetches 4-bit opcodes
//            and AW-bit operands from an asynchronous program ROM and keeps a
//            return stack for JMP/RTN. It also provides a halt/resume
//            mechanism driven by the ICU's FLAG_F strobe.
// Ports    : x2        - clock shared with the ICU (all updates on posedge)
//            rst_n     - asynchronous active-low reset
//            rom_addr  - program memory address (= PC)
//            rom_data  - program word {opcode[3:0], operand[AW-1:0]}
//            i         - opcode presented to the ICU (= IR)
//            io_addr   - operand of current instruction (= OPR)
//            jmp/rtn/flag_f - decoded ICU strobes for the current instruction
//            run       - resume request while halted
//            halted    - sequencer halted
//            stk_ovf/stk_unf - sticky return-stack overflow / underflow
//            sp        - number of valid return-stack entries
// Revision : 1.0 - initial release
// ============================================================================
module mc14500_seq #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       x2,
    input  logic                       rst_n,
    output logic [AW-1:0]              rom_addr,
    input  logic [AW+3:0]              rom_data,
    output logic [3:0]                 i,
    output logic [AW-1:0]              io_addr,
    input  logic                       jmp,
    input  logic                       rtn,
    input  logic                       flag_f,
    input  logic                       run,
    output logic                       halted,
    output logic                       stk_ovf,
    output logic                       stk_unf,
    output logic [$clog2(DEPTH+1)-1:0] sp
);

    localparam int              SPW     = $clog2(DEPTH + 1);
    localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0]  SP_FULL = SPW'(DEPTH);
    localparam logic [3:0]      NOPO    = 4'h0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [3:0]      ir_q, ir_d;
    logic [AW-1:0]   opr_q, opr_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic [AW-1:0]   stack [DEPTH];
    logic            push;
    logic [SPW-1:0]  sp_m1;
    logic [IW-1:0]   push_idx;
    logic [IW-1:0]   top_idx;

    assign sp_m1    = sp_q - 1'b1;
    assign push_idx = sp_q[IW-1:0];
    assign top_idx  = sp_m1[IW-1:0];

    // Next-state logic. Any redirect (JMP, RTN, halt entry) and every cycle
    // spent halted loads a NOPO bubble. This ensures that the ICU never executes
    // the word that sat behind the redirecting instruction.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = NOPO;
        opr_d   = '0;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;

        case (state_q)
            ST_HALT: begin
                // Strobes are ignored here. RUN only clears the halt; the
                // fetch at PC happens on the following edge.
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (jmp) begin
                    // pc_q already points past the JMP word, so it is the
                    // return address.
                    if (sp_q < SP_FULL) begin
                        push = 1'b1;
                        sp_d = sp_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    pc_d = opr_q;
                end else if (rtn) begin
                    if (sp_q != '0) begin
                        pc_d = stack[top_idx];
                        sp_d = sp_m1;
                    end else begin
                        pc_d  = '0;
                        unf_d = 1'b1;
                    end
                end else if (flag_f) begin
                    state_d = ST_HALT;
                end else begin
                    ir_d  = rom_data[AW+3:AW];
                    opr_d = rom_data[AW-1:0];
                    pc_d  = pc_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge x2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            ir_q    <= NOPO;
            opr_q   <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents need no reset because SP marks which entries are valid.
    // The write is gated by rst_n so that a JMP strobe that is still high
    // while reset is held cannot leave a stale push behind.
    always_ff @(posedge x2) begin
        if (push && rst_n) begin
            stack[push_idx] <= pc_q;
        end
    end

    assign rom_addr = pc_q;
    assign i        = ir_q;
    assign io_addr  = opr_q;
    assign sp       = sp_q;
    assign halted   = (state_q == ST_HALT);
    assign stk_ovf  = ovf_q;
    assign stk_unf  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_mc14500_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc14500_seq
// Purpose  : Self-checking bench for mc14500_seq. It provides a behavioural ROM
//            and a minimal ICU decode (C=JMP, D=RTN, F=NOPF). Expected register
//            states are queued when the stimulus is driven. They are checked
//            after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc14500_seq;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           run   = 1'b0;
    logic [AW-1:0]  rom_addr;
    logic [AW+3:0]  rom_data;
    logic [3:0]     i;
    logic [AW-1:0]  io_addr;
    logic           jmp, rtn, flag_f;
    logic           halted, stk_ovf, stk_unf;
    logic [2:0]     sp;

    logic [AW+3:0]  rom [256];

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];
    assign jmp      = (i == 4'hC);
    assign rtn      = (i == 4'hD);
    assign flag_f   = (i == 4'hF);

    mc14500_seq #(.AW(AW), .DEPTH(DEPTH)) dut (
        .x2       (clk),
        .rst_n    (rst_n),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .i        (i),
        .io_addr  (io_addr),
        .jmp      (jmp),
        .rtn      (rtn),
        .flag_f   (flag_f),
        .run      (run),
        .halted   (halted),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf),
        .sp       (sp)
    );

    typedef struct {
        int         img;
        logic       rn;
        logic       rq;
        logic [7:0] pc;
        logic [3:0] ir;
        logic [7:0] opr;
        logic [2:0] sp;
        logic       h;
        logic       o;
        logic       u;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] pc;
        logic [3:0] ir;
        logic [7:0] opr;
        logic [2:0] sp;
        logic       h;
        logic       o;
        logic       u;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   vid   = 0;

    task automatic load_img(input int id);
        for (int k = 0; k < 256; k++) rom[k] = '0;
        case (id)
            0: begin
                rom[8'h00] = 12'h105; rom[8'h01] = 12'h806;
                rom[8'h02] = 12'h507; rom[8'h03] = 12'h808;
            end
            1: begin
                rom[8'h00] = 12'h105; rom[8'h01] = 12'h806;
                rom[8'h02] = 12'hC40; rom[8'h03] = 12'h809;
                rom[8'h40] = 12'hD00;
            end
            2: begin
                rom[8'h00] = 12'hC10; rom[8'h10] = 12'hC20;
                rom[8'h20] = 12'hC30; rom[8'h30] = 12'hC40;
                rom[8'h40] = 12'hC50; rom[8'h50] = 12'h10A;
                rom[8'h51] = 12'hD00; rom[8'h31] = 12'hC40;
            end
            3: begin
                rom[8'h00] = 12'hD00;
                for (int k = 1; k <= 8; k++) rom[k] = 12'h100 | 12'(k);
                rom[8'h09] = 12'hF00;
                rom[8'h0A] = 12'h1AA; rom[8'h0B] = 12'h8BB;
            end
            default: begin
                rom[8'h00] = 12'hCFE; rom[8'hFE] = 12'h111;
                rom[8'hFF] = 12'h522;
            end
        endcase
    endtask

    task automatic v(input int img, input logic rn, input logic rq,
                     input logic [7:0] pc, input logic [3:0] ir, input logic [7:0] opr,
                     input logic [2:0] spv, input logic h, input logic o, input logic u);
        vec_t t;
        t.img = img; t.rn = rn; t.rq = rq; t.pc = pc; t.ir = ir; t.opr = opr;
        t.sp = spv; t.h = h; t.o = o; t.u = u;
        tbl.push_back(t);
    endtask

    // Drive one cycle's inputs at the falling edge and queue the state the
    // design must show after the next rising edge.
    task automatic es(input logic rn, input logic rq,
                      input logic [7:0] pc, input logic [3:0] ir, input logic [7:0] opr,
                      input logic [2:0] spv, input logic h, input logic o, input logic u);
        exp_t e;
        e.id = vid; vid++;
        e.pc = pc; e.ir = ir; e.opr = opr; e.sp = spv; e.h = h; e.o = o; e.u = u;
        @(negedge clk);
        rst_n = rn;
        run   = rq;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            tests++;
            if ({rom_addr, i, io_addr, sp, halted, stk_ovf, stk_unf} !==
                {mon_e.pc, mon_e.ir, mon_e.opr, mon_e.sp, mon_e.h, mon_e.o, mon_e.u}) begin
                fails++;
                $display("FAIL vec%0d: got pc=%h ir=%h opr=%h sp=%0d hlt=%b ovf=%b unf=%b, want pc=%h ir=%h opr=%h sp=%0d hlt=%b ovf=%b unf=%b",
                         mon_e.id, rom_addr, i, io_addr, sp, halted, stk_ovf, stk_unf,
                         mon_e.pc, mon_e.ir, mon_e.opr, mon_e.sp, mon_e.h, mon_e.o, mon_e.u);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        cur = -1;

        // img 0: linear run
        v(0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 0, 0);
        v(0, 1, 0, 8'h01, 4'h1, 8'h05, 0, 0, 0, 0);
        v(0, 1, 0, 8'h02, 4'h8, 8'h06, 0, 0, 0, 0);
        v(0, 1, 0, 8'h03, 4'h5, 8'h07, 0, 0, 0, 0);
        v(0, 1, 0, 8'h04, 4'h8, 8'h08, 0, 0, 0, 0);
        v(0, 1, 0, 8'h05, 4'h0, 8'h00, 0, 0, 0, 0);
        // img 1: call / return with one bubble after each redirect
        v(1, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 0, 0);
        v(1, 1, 0, 8'h01, 4'h1, 8'h05, 0, 0, 0, 0);
        v(1, 1, 0, 8'h02, 4'h8, 8'h06, 0, 0, 0, 0);
        v(1, 1, 0, 8'h03, 4'hC, 8'h40, 0, 0, 0, 0);
        v(1, 1, 0, 8'h40, 4'h0, 8'h00, 1, 0, 0, 0);
        v(1, 1, 0, 8'h41, 4'hD, 8'h00, 1, 0, 0, 0);
        v(1, 1, 0, 8'h03, 4'h0, 8'h00, 0, 0, 0, 0);
        v(1, 1, 0, 8'h04, 4'h8, 8'h09, 0, 0, 0, 0);
        v(1, 1, 0, 8'h05, 4'h0, 8'h00, 0, 0, 0, 0);
        // img 2: five nested calls overflow a 4-deep stack
        v(2, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 0, 0);
        v(2, 1, 0, 8'h01, 4'hC, 8'h10, 0, 0, 0, 0);
        v(2, 1, 0, 8'h10, 4'h0, 8'h00, 1, 0, 0, 0);
        v(2, 1, 0, 8'h11, 4'hC, 8'h20, 1, 0, 0, 0);
        v(2, 1, 0, 8'h20, 4'h0, 8'h00, 2, 0, 0, 0);
        v(2, 1, 0, 8'h21, 4'hC, 8'h30, 2, 0, 0, 0);
        v(2, 1, 0, 8'h30, 4'h0, 8'h00, 3, 0, 0, 0);
        v(2, 1, 0, 8'h31, 4'hC, 8'h40, 3, 0, 0, 0);
        v(2, 1, 0, 8'h40, 4'h0, 8'h00, 4, 0, 0, 0);
        v(2, 1, 0, 8'h41, 4'hC, 8'h50, 4, 0, 0, 0);
        v(2, 1, 0, 8'h50, 4'h0, 8'h00, 4, 0, 1, 0);
        v(2, 1, 0, 8'h51, 4'h1, 8'h0A, 4, 0, 1, 0);
        v(2, 1, 0, 8'h52, 4'hD, 8'h00, 4, 0, 1, 0);
        v(2, 1, 0, 8'h31, 4'h0, 8'h00, 3, 0, 1, 0);
        v(2, 1, 0, 8'h32, 4'hC, 8'h40, 3, 0, 1, 0);
        v(2, 1, 0, 8'h40, 4'h0, 8'h00, 4, 0, 1, 0);

        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].img != cur) begin
                @(negedge clk);
                rst_n = 1'b0;
                load_img(tbl[n].img);
                cur = tbl[n].img;
            end
            es(tbl[n].rn, tbl[n].rq, tbl[n].pc, tbl[n].ir, tbl[n].opr,
               tbl[n].sp, tbl[n].h, tbl[n].o, tbl[n].u);
        end

        // Underflow, then halt on NOPF at 9, RUN ignored on the halting edge
        @(negedge clk);
        rst_n = 1'b0;
        load_img(3);
        es(0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 0, 0);
        es(1, 0, 8'h01, 4'hD, 8'h00, 0, 0, 0, 0);
        es(1, 0, 8'h00, 4'h0, 8'h00, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        rom[8'h00] = 12'h100;
        es(1, 0, 8'h01, 4'h1, 8'h00, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++)
            es(1, 0, 8'(k + 1), 4'h1, 8'(k), 0, 0, 0, 1);
        es(1, 0, 8'h0A, 4'hF, 8'h00, 0, 0, 0, 1);
        es(1, 1, 8'h0A, 4'h0, 8'h00, 0, 1, 0, 1);
        es(1, 0, 8'h0A, 4'h0, 8'h00, 0, 1, 0, 1);
        es(1, 1, 8'h0A, 4'h0, 8'h00, 0, 0, 0, 1);
        es(1, 0, 8'h0B, 4'h1, 8'hAA, 0, 0, 0, 1);

        // PC wrap, then reset asserted while a JMP is pending
        @(negedge clk);
        rst_n = 1'b0;
        load_img(4);
        es(0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 0, 0);
        es(1, 0, 8'h01, 4'hC, 8'hFE, 0, 0, 0, 0);
        es(1, 0, 8'hFE, 4'h0, 8'h00, 1, 0, 0, 0);
        es(1, 0, 8'hFF, 4'h1, 8'h11, 1, 0, 0, 0);
        es(1, 0, 8'h00, 4'h5, 8'h22, 1, 0, 0, 0);
        es(1, 0, 8'h01, 4'hC, 8'hFE, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({rom_addr, i, io_addr, sp, halted, stk_ovf, stk_unf} !== 27'd0) begin
            fails++;
            $display("FAIL async_reset: got pc=%h ir=%h opr=%h sp=%0d hlt=%b ovf=%b unf=%b, want all zero",
                     rom_addr, i, io_addr, sp, halted, stk_ovf, stk_unf);
        end
        es(0, 0, 8'h00, 4'h0, 8'h00, 0, 0, 0, 0);
        es(1, 0, 8'h01, 4'hC, 8'hFE, 0, 0, 0, 0);
        es(1, 0, 8'hFE, 4'h0, 8'h00, 1, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
